// File: rtl/count_event_monitor.sv
// Watches an upstream counter bus: flags wraps and compare matches, counts wraps
// since arming, and raises a sticky interrupt when the armed wrap/match condition occurs.
module count_event_monitor #(
   parameter int CW = 4,
   parameter int WW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] count,
   input  logic [CW-1:0] cmp_val,
   input  logic [WW-1:0] wrap_limit,
   input  logic          arm,
   input  logic          ack,
   output logic          wrap_pulse,
   output logic          match_pulse,
   output logic [WW-1:0] wraps,
   output logic          irq,
   output logic          busy
);

   typedef enum logic [1:0] {IDLE, ARMED, FIRED} state_t;

   state_t        state;
   logic [CW-1:0] prev;
   logic          prev_vld;
   logic [WW-1:0] limit_q;
   logic [WW-1:0] wraps_next;
   logic          wrap_det;
   logic          match_det;

   assign wrap_det  = prev_vld && (prev == {CW{1'b1}}) && (count == '0);
   // Edge-qualified so a stalled counter sitting on cmp_val fires only once.
   assign match_det = prev_vld && (count == cmp_val) && (count != prev);

   always_comb begin
      wraps_next = wraps;
      if (wrap_det && (wraps != {WW{1'b1}}))
         wraps_next = wraps + WW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prev        <= '0;
         prev_vld    <= 1'b0;
         limit_q     <= '0;
         wrap_pulse  <= 1'b0;
         match_pulse <= 1'b0;
         wraps       <= '0;
         irq         <= 1'b0;
         busy        <= 1'b0;
      end else begin
         prev        <= count;
         prev_vld    <= 1'b1;
         wrap_pulse  <= wrap_det;
         match_pulse <= match_det;
         case (state)
            IDLE: begin
               if (arm) begin
                  state   <= ARMED;
                  limit_q <= wrap_limit;
                  wraps   <= '0;
                  busy    <= 1'b1;
               end
            end
            ARMED: begin
               // A re-arm restarts the measurement and drops this cycle's events.
               if (arm) begin
                  limit_q <= wrap_limit;
                  wraps   <= '0;
               end else begin
                  wraps <= wraps_next;
                  if (match_det && (wraps_next == limit_q)) begin
                     state <= FIRED;
                     irq   <= 1'b1;
                     busy  <= 1'b0;
                  end
               end
            end
            FIRED: begin
               if (ack) begin
                  state <= IDLE;
                  irq   <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               irq   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: a vector table for reset and the
// limit-0 flow, then hand-written sequences for multi-cycle corner cases.
module tb_count_event_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] count, cmp_val, cmp2;
   logic [7:0] wrap_limit;
   logic [1:0] wl2;
   logic       arm, ack, arm2, ack2;
   logic       wrap_pulse, match_pulse, irq, busy;
   logic [7:0] wraps;
   logic       wp2, mp2, irq2, busy2;
   logic [1:0] wraps2;

   int passed = 0;
   int total  = 0;
   int c      = 0;

   always #5 clk = ~clk;

   count_event_monitor #(.CW(4), .WW(8)) dut (
      .clk(clk), .rst(rst), .count(count), .cmp_val(cmp_val),
      .wrap_limit(wrap_limit), .arm(arm), .ack(ack),
      .wrap_pulse(wrap_pulse), .match_pulse(match_pulse), .wraps(wraps),
      .irq(irq), .busy(busy));

   count_event_monitor #(.CW(4), .WW(2)) dut2 (
      .clk(clk), .rst(rst), .count(count), .cmp_val(cmp2),
      .wrap_limit(wl2), .arm(arm2), .ack(ack2),
      .wrap_pulse(wp2), .match_pulse(mp2), .wraps(wraps2),
      .irq(irq2), .busy(busy2));

   typedef struct {
      int rst, cnt, cmp, wl, arm, ack;
      int wp, mp, wraps, irq, busy;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic chk_all(input string nm, input int e_wp, input int e_mp,
                          input int e_wraps, input int e_irq, input int e_busy);
      chk({nm, ".wrap_pulse"},  int'(wrap_pulse),  e_wp);
      chk({nm, ".match_pulse"}, int'(match_pulse), e_mp);
      chk({nm, ".wraps"},       int'(wraps),       e_wraps);
      chk({nm, ".irq"},         int'(irq),         e_irq);
      chk({nm, ".busy"},        int'(busy),        e_busy);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance the modelled upstream counter by one and clock it in.
   task automatic tick(input logic a, input logic k);
      c     = (c + 1) % 16;
      count = 4'(c);
      arm   = a;
      ack   = k;
      step();
   endtask

   initial begin
      rst = 1'b1; count = 4'd15; cmp_val = 4'd5; wrap_limit = 8'd0;
      arm = 1'b0; ack = 1'b0; arm2 = 1'b0; ack2 = 1'b0; cmp2 = 4'd7; wl2 = 2'd0;

      //          rst cnt cmp wl arm ack  wp mp wraps irq busy
      vecs[0]  = '{1, 15, 5, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[1]  = '{1, 15, 5, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[2]  = '{0,  0, 5, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[3]  = '{0,  1, 5, 0, 0, 0,   0, 0, 0, 0, 0};
      vecs[4]  = '{0,  2, 5, 0, 1, 0,   0, 0, 0, 0, 1};
      vecs[5]  = '{0,  3, 5, 0, 0, 0,   0, 0, 0, 0, 1};
      vecs[6]  = '{0,  4, 5, 0, 0, 0,   0, 0, 0, 0, 1};
      vecs[7]  = '{0,  5, 5, 0, 0, 0,   0, 1, 0, 1, 0};
      vecs[8]  = '{0,  6, 5, 0, 0, 0,   0, 0, 0, 1, 0};
      vecs[9]  = '{0,  7, 5, 0, 0, 0,   0, 0, 0, 1, 0};
      vecs[10] = '{0,  8, 5, 0, 0, 1,   0, 0, 0, 0, 0};
      vecs[11] = '{0,  9, 5, 0, 0, 0,   0, 0, 0, 0, 0};

      for (int i = 0; i < 12; i++) begin
         rst        = vecs[i].rst[0];
         count      = vecs[i].cnt[3:0];
         cmp_val    = vecs[i].cmp[3:0];
         wrap_limit = vecs[i].wl[7:0];
         arm        = vecs[i].arm[0];
         ack        = vecs[i].ack[0];
         step();
         chk_all($sformatf("vec%0d", i), vecs[i].wp, vecs[i].mp, vecs[i].wraps,
                 vecs[i].irq, vecs[i].busy);
      end
      c = 9;

      // Free-run in IDLE: pulses still fire, nothing counted.
      for (int k = 0; k < 34; k++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("freerun%0d.wrap_pulse", k), int'(wrap_pulse), (c == 0) ? 1 : 0);
         chk($sformatf("freerun%0d.match_pulse", k), int'(match_pulse), (c == 5) ? 1 : 0);
      end
      chk("freerun.wraps", int'(wraps), 0);
      chk("freerun.busy", int'(busy), 0);

      // Limit 2: fires 40 edges after the arm edge.
      cmp_val = 4'd10; wrap_limit = 8'd2;
      while (c != 1) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("lim2_%0d.wraps", k), int'(wraps), (k >= 30) ? 2 : (k >= 14) ? 1 : 0);
         chk($sformatf("lim2_%0d.wrap_pulse", k), int'(wrap_pulse), (k == 14 || k == 30) ? 1 : 0);
         chk($sformatf("lim2_%0d.irq", k), int'(irq), (k == 40) ? 1 : 0);
         chk($sformatf("lim2_%0d.busy", k), int'(busy), (k < 40) ? 1 : 0);
      end
      tick(1'b0, 1'b1);
      chk_all("lim2_ack", 0, 0, 2, 0, 0);

      // Coincident wrap and match with cmp_val = 0.
      cmp_val = 4'd0; wrap_limit = 8'd1;
      tick(1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("coin%0d.irq", k), int'(irq), 0);
      end
      tick(1'b0, 1'b0);
      chk_all("coin_fire", 1, 1, 1, 1, 0);

      // arm and ack together in FIRED: ack wins, arm ignored.
      tick(1'b1, 1'b1);
      chk_all("armack", 0, 0, 1, 0, 0);
      tick(1'b0, 1'b0);
      chk("armack_after.busy", int'(busy), 0);

      // Re-arm mid-measurement clears wraps.
      cmp_val = 4'd3; wrap_limit = 8'd5;
      tick(1'b1, 1'b0);
      for (int k = 0; k < 13; k++) tick(1'b0, 1'b0);
      chk("rearm_pre.wraps", int'(wraps), 1);
      chk("rearm_pre.busy", int'(busy), 1);
      tick(1'b1, 1'b0);
      chk("rearm.wraps", int'(wraps), 0);
      chk("rearm.busy", int'(busy), 1);

      // Reset while ARMED clears everything.
      rst = 1'b1;
      tick(1'b0, 1'b0);
      chk_all("rst_armed", 0, 0, 0, 0, 0);
      rst = 1'b0;

      // Saturation on the 2-bit wrap counter.
      cmp2 = 4'd7; wl2 = 2'd3;
      count = 4'd1; arm2 = 1'b1;
      step();
      arm2 = 1'b0;
      chk("sat_arm.busy", int'(busy2), 1);
      for (int i = 0; i < 5; i++) begin
         count = 4'd15; step();
         count = 4'd0;  step();
         chk($sformatf("sat%0d.wraps", i), int'(wraps2), (i >= 2) ? 3 : i + 1);
         chk($sformatf("sat%0d.irq", i), int'(irq2), 0);
         chk($sformatf("sat%0d.busy", i), int'(busy2), 1);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
